// File: rtl/motion_count_bcd.sv
// Purpose : binary motion count -> decimal digits (sequential double-dabble), committed to display at a fixed raster line.
// Latency : request in cycle N -> busy N+1..N+COUNT_WIDTH, done_out in N+COUNT_WIDTH+1; digits_out changes at the next commit line.
// Backpress: none; requests arriving while converting go to a single-entry pending slot (latest wins), never aborting the active conversion.
//
// Ports:
//   pixel_clk_in   - pixel clock (only clock)
//   rst_n_in       - asynchronous active-low reset
//   count_in       - binary count to convert, sampled when count_valid_in is high
//   count_valid_in - single-cycle conversion request
//   hcount_in      - raster horizontal position
//   vcount_in      - raster vertical position
//   digits_out     - committed digits, digit i at [4i+3:4i], digit 0 least significant, 4'hF = blank
//   busy_out       - converter is shifting
//   done_out       - one-cycle pulse after the shadow register was updated
//   commit_out     - one-cycle pulse after digits_out was updated
module motion_count_bcd #(
  parameter int COUNT_WIDTH   = 16,
  parameter int NUM_DIGITS    = 5,
  parameter int COMMIT_LINE   = 720,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_n_in,
  input  logic [COUNT_WIDTH-1:0]  count_in,
  input  logic                    count_valid_in,
  input  logic [10:0]             hcount_in,
  input  logic [9:0]              vcount_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    commit_out
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + COUNT_WIDTH;
  localparam int CNT_W = $clog2(COUNT_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Replace leading zero digits (never digit 0) by the blank code.
  function automatic logic [BCD_W-1:0] blank_digits(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    logic             lead;
    res  = bcd;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lead && (bcd[4*i +: 4] == 4'd0)) begin
        if (BLANK_LEADING != 0) begin
          res[4*i +: 4] = 4'hF;
        end
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

  state_t                   state_q, state_d;
  logic [SR_W-1:0]          sr_q;        // {bcd accumulator, binary remainder}
  logic [SR_W-1:0]          sr_adj;
  logic [SR_W-1:0]          sr_nxt;
  logic [CNT_W-1:0]         cnt_q;
  logic [BCD_W-1:0]         shadow_q;
  logic [BCD_W-1:0]         digits_q;
  logic                     commit_q;
  logic                     pend_vld_q;
  logic [COUNT_WIDTH-1:0]   pend_dat_q;
  logic                     load;
  logic [COUNT_WIDTH-1:0]   load_dat;
  logic                     last_shift;
  logic                     commit_hit;

  assign last_shift = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(1));
  assign commit_hit = (vcount_in == 10'(COMMIT_LINE)) && (hcount_in == 11'd0);
  // A request presented in the same cycle as a pending one is newer, so it wins.
  assign load_dat   = count_valid_in ? count_in : pend_dat_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_valid_in) begin
          state_d = ST_SHIFT;
          load    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (pend_vld_q || count_valid_in) begin
          state_d = ST_SHIFT;
          load    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // One double-dabble step: add 3 to each BCD nibble >= 5 (no inter-nibble
  // carry), then shift the whole {bcd, bin} vector left by one.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sr_q[COUNT_WIDTH + 4*i +: 4] >= 4'd5) begin
        sr_adj[COUNT_WIDTH + 4*i +: 4] = sr_q[COUNT_WIDTH + 4*i +: 4] + 4'd3;
      end
    end
    sr_nxt = sr_adj << 1;
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
    end else begin
      if (load) begin
        sr_q  <= {{BCD_W{1'b0}}, load_dat};
        cnt_q <= CNT_W'(COUNT_WIDTH);
      end else if (state_q == ST_SHIFT) begin
        sr_q  <= sr_nxt;
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (last_shift) begin
        shadow_q <= sr_nxt[SR_W-1 -: BCD_W];
      end

      if (load) begin
        pend_vld_q <= 1'b0;
      end else if (count_valid_in && (state_q != ST_IDLE)) begin
        pend_vld_q <= 1'b1;
        pend_dat_q <= count_in;
      end
    end
  end

  // Commit reads shadow_q before any same-edge write, so a conversion that
  // finishes on the commit edge shows up one frame later.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      digits_q <= blank_digits('0);
      commit_q <= 1'b0;
    end else begin
      commit_q <= commit_hit;
      if (commit_hit) begin
        digits_q <= blank_digits(shadow_q);
      end
    end
  end

  assign digits_out = digits_q;
  assign commit_out = commit_q;
  assign busy_out   = (state_q == ST_SHIFT);
  assign done_out   = (state_q == ST_DONE);

endmodule

// File: tb/tb_motion_count_bcd.sv
// Purpose : scoreboard bench for motion_count_bcd; stimulus queues expected commits/done cycles, a monitor checks them.
// Latency : done expected 17 cycles after a request; commit_out one cycle after vcount=720,hcount=0.
// Backpress: n/a (bench).
module tb_motion_count_bcd;

  localparam int H_TOT = 4;
  localparam int V_TOT = 725;

  logic        pixel_clk_in = 1'b0;
  logic        rst_n_in;
  logic [15:0] count_in;
  logic        count_valid_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [19:0] digits_out;
  logic        busy_out;
  logic        done_out;
  logic        commit_out;

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;
  int commit_seen = 0;

  logic [19:0] exp_commit_q[$];
  int          exp_done_q[$];

  motion_count_bcd #(
    .COUNT_WIDTH(16),
    .NUM_DIGITS(5),
    .COMMIT_LINE(720),
    .BLANK_LEADING(1)
  ) dut (
    .pixel_clk_in  (pixel_clk_in),
    .rst_n_in      (rst_n_in),
    .count_in      (count_in),
    .count_valid_in(count_valid_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .digits_out    (digits_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .commit_out    (commit_out)
  );

  initial begin
    forever #5 pixel_clk_in = ~pixel_clk_in;
  end

  initial begin
    forever begin
      @(posedge pixel_clk_in);
      cyc++;
    end
  end

  // Compact free-running raster: 4 pixels per line, 725 lines per frame.
  initial begin
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    forever begin
      @(posedge pixel_clk_in);
      #1;
      if (hcount_in == 11'(H_TOT - 1)) begin
        hcount_in = 11'd0;
        vcount_in = (vcount_in == 10'(V_TOT - 1)) ? 10'd0 : vcount_in + 10'd1;
      end else begin
        hcount_in = hcount_in + 11'd1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic        cond_prev;
    int          busy_run;
    logic [19:0] e_dig;
    int          e_cyc;
    cond_prev = 1'b0;
    busy_run  = 0;
    forever begin
      @(negedge pixel_clk_in);
      if (commit_out || cond_prev) begin
        asserts++;
        if (commit_out !== cond_prev) begin
          fails++;
          $display("FAIL commit_timing: commit_out=%b required %b at cycle %0d", commit_out, cond_prev, cyc);
        end
      end
      if (commit_out) begin
        commit_seen++;
        asserts++;
        if (exp_commit_q.size() == 0) begin
          fails++;
          $display("FAIL commit_unexpected: digits_out=%h with no expected commit at cycle %0d", digits_out, cyc);
        end else begin
          e_dig = exp_commit_q.pop_front();
          if (digits_out !== e_dig) begin
            fails++;
            $display("FAIL commit_digits: digits_out=%h required %h at cycle %0d", digits_out, e_dig, cyc);
          end
        end
      end
      if (done_out) begin
        asserts++;
        if (exp_done_q.size() == 0) begin
          fails++;
          $display("FAIL done_unexpected: done_out=1 with no conversion expected at cycle %0d", cyc);
        end else begin
          e_cyc = exp_done_q.pop_front();
          if (cyc != e_cyc) begin
            fails++;
            $display("FAIL done_cycle: done_out at cycle %0d required %0d", cyc, e_cyc);
          end
          asserts++;
          if (busy_run != 16 || busy_out !== 1'b0) begin
            fails++;
            $display("FAIL busy_window: busy run %0d (busy now %b) required 16 (0)", busy_run, busy_out);
          end
        end
      end
      if (done_out) busy_run = 0;
      else if (busy_out === 1'b1) busy_run++;
      else busy_run = 0;
      cond_prev = rst_n_in && (vcount_in == 10'd720) && (hcount_in == 11'd0);
    end
  end

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
    asserts++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic pulse(input logic [15:0] v, input bit expect_done);
    @(posedge pixel_clk_in);
    #2;
    count_in       = v;
    count_valid_in = 1'b1;
    if (expect_done) exp_done_q.push_back(cyc + 17);
    @(posedge pixel_clk_in);
    #2;
    count_valid_in = 1'b0;
  endtask

  task automatic wait_commit(input logic [19:0] e);
    int start;
    exp_commit_q.push_back(e);
    start = commit_seen;
    for (int i = 0; i < 4000 && commit_seen == start; i++) @(posedge pixel_clk_in);
    if (commit_seen == start) begin
      asserts++;
      fails++;
      $display("FAIL commit_timeout: no commit within 4000 cycles, expected digits %h", e);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_busy"},   {19'd0, busy_out},   20'd0);
    check({tag, "_done"},   {19'd0, done_out},   20'd0);
    check({tag, "_commit"}, {19'd0, commit_out}, 20'd0);
    check({tag, "_digits"}, digits_out,          20'hFFFF0);
  endtask

  initial begin
    int n;
    int guard;
    rst_n_in       = 1'b0;
    count_in       = 16'd0;
    count_valid_in = 1'b0;
    repeat (3) @(posedge pixel_clk_in);
    #2;
    reset_checks("reset");
    rst_n_in = 1'b1;

    // Idle frame: blank display with a single 0.
    wait_commit(20'hFFFF0);

    pulse(16'd1234, 1'b1);   wait_commit(20'hF1234);
    pulse(16'd65535, 1'b1);  wait_commit(20'h65535);
    pulse(16'd0, 1'b1);      wait_commit(20'hFFFF0);
    pulse(16'd10, 1'b1);     wait_commit(20'hFFF10);

    // 100 converts; 200 is overwritten by 300 in the pending slot.
    @(posedge pixel_clk_in);
    #2;
    n = cyc;
    count_in = 16'd100; count_valid_in = 1'b1;
    exp_done_q.push_back(n + 17);
    exp_done_q.push_back(n + 34);
    @(posedge pixel_clk_in); #2; count_valid_in = 1'b0;
    repeat (2) @(posedge pixel_clk_in);
    #2;
    count_in = 16'd200; count_valid_in = 1'b1;
    @(posedge pixel_clk_in); #2; count_valid_in = 1'b0;
    @(posedge pixel_clk_in); #2;
    count_in = 16'd300; count_valid_in = 1'b1;
    @(posedge pixel_clk_in); #2; count_valid_in = 1'b0;
    wait_commit(20'hFF300);

    // Shadow write coinciding with the commit edge.
    pulse(16'd7, 1'b1);
    wait_commit(20'hFFFF7);
    guard = 0;
    do begin
      @(posedge pixel_clk_in);
      #2;
      guard++;
    end while (!(vcount_in == 10'd716 && hcount_in == 11'd0) && guard < 4000);
    if (guard >= 4000) begin
      asserts++;
      fails++;
      $display("FAIL align_timeout: raster line 716 not reached, got %0d", vcount_in);
    end
    count_in = 16'd42; count_valid_in = 1'b1;
    exp_done_q.push_back(cyc + 17);
    @(posedge pixel_clk_in); #2; count_valid_in = 1'b0;
    wait_commit(20'hFFFF7);
    wait_commit(20'hFFF42);

    // Reset mid-conversion with a pending request queued.
    pulse(16'd5555, 1'b0);
    @(posedge pixel_clk_in); #2;
    count_in = 16'd777; count_valid_in = 1'b1;
    @(posedge pixel_clk_in); #2; count_valid_in = 1'b0;
    check("busy_before_reset", {19'd0, busy_out}, 20'd1);
    @(posedge pixel_clk_in); #2;
    rst_n_in = 1'b0;
    #1;
    reset_checks("midreset");
    repeat (2) @(posedge pixel_clk_in);
    #2;
    rst_n_in = 1'b1;
    wait_commit(20'hFFFF0);
    pulse(16'd9, 1'b1);
    wait_commit(20'hFFFF9);

    repeat (20) @(posedge pixel_clk_in);
    check("done_queue_left", 20'(exp_done_q.size()), 20'd0);
    check("commit_queue_left", 20'(exp_commit_q.size()), 20'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
